// File: rtl/key_debounce.sv
// Debounced push-button front end: synchroniser, debounce FSM,
// registered level plus press / release / long-press pulses.
//
// Ports:
//   clk         system clock, all flops on rising edge
//   rst_n       asynchronous active-low reset
//   button      raw key input, asynchronous, 1 = pressed
//   key_level   debounced key state
//   key_press   one-cycle pulse on confirmed press
//   key_release one-cycle pulse on confirmed release
//   key_long    one-cycle pulse once per press held past LONG_CNT+1 cycles
module key_debounce #(
   parameter logic [20:0] DEB_CNT  = 21'd1_999_999,
   parameter logic [26:0] LONG_CNT = 27'd99_999_999
) (
   input  logic clk,
   input  logic rst_n,
   input  logic button,
   output logic key_level,
   output logic key_press,
   output logic key_release,
   output logic key_long
);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_CHK,
      PRESSED,
      RELEASE_CHK
   } state_t;

   localparam logic [26:0] DEB_W = 27'(DEB_CNT);

   logic        s1_q, s2_q;
   state_t      state_q, state_d;
   logic [26:0] cnt_q, cnt_d;
   logic        long_done_q, long_done_d;
   logic        level_q, level_d;
   logic        press_q, press_d;
   logic        release_q, release_d;
   logic        long_q, long_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q        <= 1'b0;
         s2_q        <= 1'b0;
         state_q     <= IDLE;
         cnt_q       <= '0;
         long_done_q <= 1'b0;
         level_q     <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         long_q      <= 1'b0;
      end else begin
         s1_q        <= button;
         s2_q        <= s1_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         long_done_q <= long_done_d;
         level_q     <= level_d;
         press_q     <= press_d;
         release_q   <= release_d;
         long_q      <= long_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      long_done_d = long_done_q;
      level_d     = level_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      long_d      = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (s2_q) begin
               state_d = PRESS_CHK;
            end
         end
         PRESS_CHK: begin
            if (!s2_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DEB_W) begin
               state_d = PRESSED;
               cnt_d   = '0;
               level_d = 1'b1;
               press_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 27'd1;
            end
         end
         PRESSED: begin
            if (!s2_q) begin
               state_d = RELEASE_CHK;
               cnt_d   = '0;
            end else if (cnt_q < LONG_CNT) begin
               cnt_d = cnt_q + 27'd1;
            end else if (!long_done_q) begin
               // counter saturates; long_done keeps this to one pulse
               long_d      = 1'b1;
               long_done_d = 1'b1;
            end
         end
         RELEASE_CHK: begin
            if (s2_q) begin
               // bounce during release: back to held, long_done kept
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == DEB_W) begin
               state_d     = IDLE;
               cnt_d       = '0;
               level_d     = 1'b0;
               release_d   = 1'b1;
               long_done_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 27'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign key_level   = level_q;
   assign key_press   = press_q;
   assign key_release = release_q;
   assign key_long    = long_q;

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter DEB_CNT, default 21'd1_999_999, giving the debounce window as DEB_CNT+1 clk cycles (20 ms at 100 MHz).
REQ-002 SHALL have parameter LONG_CNT, default 27'd99_999_999, giving the long-press threshold as LONG_CNT+1 cycles after press confirmation (1 s at 100 MHz).
REQ-003 clk  input  1  single system clock; all flops on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 button  input  1  raw mechanical key, asynchronous to clk, active-high (1 = pressed).
REQ-006 key_level  output  1  debounced key state, registered.
REQ-007 key_press  output  1  one-cycle pulse per confirmed press, registered.
REQ-008 key_release  output  1  one-cycle pulse per confirmed release, registered.
REQ-009 key_long  output  1  one-cycle pulse when a press is held past the threshold; at most once per press, registered.

Function
REQ-010 button SHALL pass through a two-flop synchronizer (s1, s2); only s2 feeds the FSM.
REQ-011 FSM states SHALL be IDLE, PRESS_CHK, PRESSED and RELEASE_CHK, with one shared counter cnt 27 bits wide.
REQ-012 IDLE: when s2=1, the FSM SHALL go to PRESS_CHK with cnt<=0; otherwise it stays in IDLE.
REQ-013 PRESS_CHK, s2=0: the FSM SHALL return to IDLE with cnt<=0 and no output pulse.
REQ-014 PRESS_CHK, s2=1: when cnt<DEB_CNT, cnt SHALL increment; when cnt==DEB_CNT, the FSM SHALL go to PRESSED with cnt<=0, key_level<=1 and key_press<=1 for that one cycle.
REQ-015 PRESSED, s2=1: when cnt<LONG_CNT, cnt SHALL increment; when cnt==LONG_CNT and long_done=0, key_long<=1 for one cycle and long_done<=1; cnt SHALL then saturate and not wrap.
REQ-016 PRESSED, s2=0: the FSM SHALL go to RELEASE_CHK with cnt<=0 while long_done is kept.
REQ-017 RELEASE_CHK, s2=1: the FSM SHALL return to PRESSED with cnt<=0, no pulse, and long_done kept, so key_long cannot repeat within the same press.
REQ-018 RELEASE_CHK, s2=0: cnt SHALL increment until cnt==DEB_CNT; it SHALL then go to IDLE with key_level<=0, key_release<=1 for one cycle and long_done<=0.
REQ-019 key_press, key_release and key_long SHALL otherwise be 0; no two of them SHALL be high in the same cycle.
REQ-020 Press latency SHALL be exactly DEB_CNT+4 clk edges, counted from the first edge that samples button=1, to key_press high (2 sync + 1 entry + DEB_CNT+1 count).
REQ-021 Release latency SHALL be DEB_CNT+4 edges, symmetric to press latency.
REQ-022 Any glitch on s2 shorter than DEB_CNT+1 cycles SHALL leave key_level unchanged and produce no pulse.

Reset
REQ-023 rst_n=0 SHALL immediately, without clk, force s1=s2=0, state=IDLE, cnt=0, long_done=0, and all four outputs to 0.
REQ-024 Reset asserted mid-press SHALL NOT generate key_release; after rst_n rises with button held, a fresh press SHALL be confirmed with full REQ-020 latency.
REQ-025 Release of rst_n SHALL be taken as synchronous to clk by the surrounding system; the block needs no internal reset synchronizer.

Verification (DEB_CNT=9, LONG_CNT=49)
REQ-026 Clean press: button 0->1 and held -> key_press high exactly on edge 13 after first sampling, key_level=1 from the same edge, key_release=0.
REQ-027 Bounce: button toggles 1,0,1,0 with each level held 5 cycles, then stays 1 -> single key_press, 13 edges after the final rise; no pulse during bouncing.
REQ-028 Long press: hold button 100 cycles after key_press -> exactly one key_long pulse, 50 cycles after key_press; a 3-cycle low dip afterwards produces no second key_long and no key_release.
REQ-029 Release: button 1->0 after confirmed press -> key_release one cycle wide at edge 13, key_level=0 from the same edge.
REQ-030 Reset mid-operation: assert rst_n=0 while in PRESSED -> all outputs 0 asynchronously, no key_release; deassert with button=1 -> key_press after 13 edges.
REQ-031 Pulse exclusivity: random button stimulus for 10k cycles -> key_press and key_release strictly alternate, starting with key_press, and never more than one output pulse is high per cycle.
